// File: rtl/boid_frame_writer_pkg.sv
// Shared constants and FSM state type for the per-frame boid display writer.
// Screen geometry defaults match the 640x480 VGA timing used elsewhere.
package boid_frame_writer_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int PIXEL_ADDR_W = 19;
  localparam int MAX_BOIDS    = 8;
  localparam int BOX_MAX      = 4;
  localparam int DELTA_W      = 2;   // enough to count 0..BOX_MAX-1
  localparam int X_W          = 10;
  localparam int Y_W          = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SELECT = 3'd2,
    DRAW   = 3'd3,
    DONE   = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/boid_frame_writer_if.sv
// Signal bundle between the frame writer, the BPU read mux and the display RAM.
// No backpressure anywhere: wr_en qualifies wr_addr each cycle and the RAM must accept every write.
interface boid_frame_writer_if
  import boid_frame_writer_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int ADDR_W = PIXEL_ADDR_W
) ();

  logic              screen_end;
  logic [X_W-1:0]    boid_x;
  logic [Y_W-1:0]    boid_y;
  logic [SEL_W-1:0]  boid_sel;
  logic              ram_clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;
  logic              overrun;
  fsm_state_t        state;

  modport master (
    input  screen_end, boid_x, boid_y,
    output boid_sel, ram_clear, wr_en, wr_addr, busy, done, overrun, state
  );

  modport slave (
    output screen_end, boid_x, boid_y,
    input  boid_sel, ram_clear, wr_en, wr_addr, busy, done, overrun, state
  );

endinterface

// File: rtl/boid_frame_writer_pixel_addr_calc.sv
// Combinational pixel address for a 640-wide frame buffer plus on-screen test.
// Coordinates are one bit wider than the screen so box overhang never wraps.
module pixel_addr_calc
  import boid_frame_writer_pkg::*;
#(
  parameter int H_RES  = boid_frame_writer_pkg::H_RES,
  parameter int V_RES  = boid_frame_writer_pkg::V_RES,
  parameter int ADDR_W = PIXEL_ADDR_W
) (
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);

  logic [19:0] y_ext;
  logic [19:0] sum;

  // y*640 = y*512 + y*128
  assign y_ext     = {10'b0, y};
  assign sum       = (y_ext << 9) + (y_ext << 7) + {9'b0, x};
  assign addr      = ADDR_W'(sum);
  assign in_bounds = (x < 11'(H_RES)) && (y < 10'(V_RES));

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame sequencer: clears the display RAM, then scans every BPU and writes
// a clipped BOX_SIZE x BOX_SIZE square per boid. All outputs are registered.
module boid_frame_writer
  import boid_frame_writer_pkg::*;
#(
  parameter int NUM_BOIDS = 8,
  parameter int SEL_W     = 3,
  parameter int BOX_SIZE  = 2,
  parameter int H_RES     = boid_frame_writer_pkg::H_RES,
  parameter int V_RES     = boid_frame_writer_pkg::V_RES,
  parameter int ADDR_W    = PIXEL_ADDR_W
) (
  input logic                 clock,
  input logic                 reset,
  boid_frame_writer_if.master bus
);

  localparam logic [DELTA_W-1:0] D_LAST   = DELTA_W'(BOX_SIZE - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(NUM_BOIDS - 1);

  fsm_state_t        state, state_d;
  logic [SEL_W-1:0]  sel, sel_d;
  logic [DELTA_W-1:0] dx, dx_d, dy, dy_d;
  logic [X_W-1:0]    bx, bx_d;
  logic [Y_W-1:0]    by, by_d;

  logic              ram_clear_r, ram_clear_d;
  logic              wr_en_r, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_d;
  logic              busy_r, busy_d;
  logic              done_r, done_d;
  logic              overrun_r, overrun_d;

  logic [10:0]       px;
  logic [9:0]        py;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_in;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    sel_d       = sel;
    dx_d        = dx;
    dy_d        = dy;
    bx_d        = bx;
    by_d        = by;
    ram_clear_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    overrun_d   = overrun_r | (bus.screen_end && (state != IDLE));

    case (state)
      IDLE: begin
        if (bus.screen_end) begin
          state_d     = CLEAR;
          sel_d       = '0;
          ram_clear_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      CLEAR: begin
        state_d = SELECT;
        sel_d   = '0;
        busy_d  = 1'b1;
      end
      SELECT: begin
        state_d = DRAW;
        bx_d    = bus.boid_x;
        by_d    = bus.boid_y;
        dx_d    = '0;
        dy_d    = '0;
        busy_d  = 1'b1;
      end
      DRAW: begin
        busy_d = 1'b1;
        if (dx == D_LAST) begin
          dx_d = '0;
          if (dy == D_LAST) begin
            dy_d = '0;
            if (sel == SEL_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              sel_d   = sel + SEL_W'(1);
              state_d = SELECT;
            end
          end else begin
            dy_d = dy + DELTA_W'(1);
          end
        end else begin
          dx_d = dx + DELTA_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel for the cycle being entered; on SELECT->DRAW this is the live mux value.
  assign px = 11'(bx_d) + 11'(dx_d);
  assign py = 10'(by_d) + 10'(dy_d);

  pixel_addr_calc #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .x         (px),
    .y         (py),
    .addr      (pix_addr),
    .in_bounds (pix_in)
  );

  assign wr_en_d   = (state_d == DRAW) && pix_in;
  assign wr_addr_d = wr_en_d ? pix_addr : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      dx          <= '0;
      dy          <= '0;
      bx          <= '0;
      by          <= '0;
      ram_clear_r <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      dx          <= dx_d;
      dy          <= dy_d;
      bx          <= bx_d;
      by          <= by_d;
      ram_clear_r <= ram_clear_d;
      wr_en_r     <= wr_en_d;
      wr_addr_r   <= wr_addr_d;
      busy_r      <= busy_d;
      done_r      <= done_d;
      overrun_r   <= overrun_d;
    end
  end

  assign bus.boid_sel  = sel;
  assign bus.ram_clear = ram_clear_r;
  assign bus.wr_en     = wr_en_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.overrun   = overrun_r;
  assign bus.state     = state;

endmodule
